// File: rtl/chany_bist_pkg.sv
// Shared types and constants for the chany track BIST.
package chany_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WALK1,
    ST_WALK0,
    ST_PRBS,
    ST_DRAIN,
    ST_DONE
  } bist_state_t;

  localparam int unsigned LFSR_W     = 31;
  localparam int unsigned LFSR_TAP   = 28;
  localparam int unsigned ERR_CNT_W  = 16;
  // Upper bound on channel width handled by the lowest-set-bit scan.
  localparam int unsigned LSB_SCAN_W = 256;

  function automatic int unsigned lowest_set(input logic [LSB_SCAN_W-1:0] v);
    int unsigned idx;
    logic        found;
    idx   = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < LSB_SCAN_W; i++) begin
      if (!found && v[i]) begin
        idx   = i;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/chany_track_bist_lfsr.sv
// Parallel-output PRBS-31 generator (x^31 + x^28 + 1) with load and step.
module chany_bist_lfsr
  import chany_bist_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 31'h1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_step,
  output logic [LFSR_W-1:0] o_state
);

  logic [LFSR_W-1:0] r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SEED;
    end else if (i_load) begin
      r_state <= SEED;
    end else if (i_step) begin
      r_state <= {r_state[LFSR_W-2:0], r_state[LFSR_W-1] ^ r_state[LFSR_TAP-1]};
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/chany_track_bist.sv
// BIST transmitter/checker for vertical routing channel tracks.
// Optional PRBS phase built when CHANY_BIST_PRBS_EN is defined.
module chany_track_bist
  import chany_bist_pkg::*;
#(
  parameter int unsigned       CHAN_WIDTH = 33,
  parameter int unsigned       RT_LAT     = 1,
  parameter int unsigned       PRBS_LEN   = 256,
  parameter logic [LFSR_W-1:0] PRBS_SEED  = 31'h1
) (
  input  logic                          clk,
  input  logic                          pReset,
  input  logic                          start,
  output logic [0:CHAN_WIDTH-1]         chany_tx,
  input  logic [0:CHAN_WIDTH-1]         chany_rx,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic [$clog2(CHAN_WIDTH)-1:0] fail_track,
  output logic [ERR_CNT_W-1:0]          err_count
);

  localparam int unsigned FT_W = $clog2(CHAN_WIDTH);
  localparam int unsigned MAX_A = (CHAN_WIDTH > PRBS_LEN) ? CHAN_WIDTH : PRBS_LEN;
  localparam int unsigned MAX_WORDS = (MAX_A > RT_LAT) ? MAX_A : RT_LAT;
  localparam int unsigned CNT_W = $clog2(MAX_WORDS + 1);

  localparam logic [CNT_W-1:0] WALK_LAST  = CNT_W'(CHAN_WIDTH - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'((RT_LAT > 1) ? RT_LAT - 2 : 0);
  // A one-cycle loop has nothing left in flight after the last word.
  localparam bist_state_t AFTER_WORDS = (RT_LAT > 1) ? ST_DRAIN : ST_DONE;

  bist_state_t                r_state;
  bist_state_t                w_state_nxt;
  logic [CNT_W-1:0]           r_cnt;
  logic [0:CHAN_WIDTH-1]      w_tx;
  logic                       w_tx_vld;
  logic                       w_accept;
  logic [0:CHAN_WIDTH-1]      w_exp;
  logic                       w_exp_vld;
  logic [LSB_SCAN_W-1:0]      w_diff_scan;
  logic                       w_mismatch;
  logic                       r_first_seen;
  logic [FT_W-1:0]            r_fail_track;
  logic [ERR_CNT_W-1:0]       r_err_count;

`ifdef CHANY_BIST_PRBS_EN
  localparam logic [CNT_W-1:0] PRBS_LAST = CNT_W'(PRBS_LEN - 1);
  logic [LFSR_W-1:0] w_lfsr;

  chany_bist_lfsr #(.SEED(PRBS_SEED)) u_lfsr (
    .clk     (clk),
    .rst     (pReset),
    .i_load  (w_accept),
    .i_step  (r_state == ST_PRBS),
    .o_state (w_lfsr)
  );
`else
  logic w_unused_seed;
  assign w_unused_seed = ^PRBS_SEED;
`endif

  assign w_accept = start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign busy     = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign done     = (r_state == ST_DONE);
  assign pass     = done && (r_err_count == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_tx        = '0;
    w_tx_vld    = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: if (start) w_state_nxt = ST_WALK1;
      ST_WALK1: begin
        w_tx_vld = 1'b1;
        for (int unsigned j = 0; j < CHAN_WIDTH; j++) w_tx[j] = (j == 32'(r_cnt));
        if (r_cnt == WALK_LAST) w_state_nxt = ST_WALK0;
      end
      ST_WALK0: begin
        w_tx_vld = 1'b1;
        for (int unsigned j = 0; j < CHAN_WIDTH; j++) w_tx[j] = (j != 32'(r_cnt));
`ifdef CHANY_BIST_PRBS_EN
        if (r_cnt == WALK_LAST) w_state_nxt = ST_PRBS;
`else
        if (r_cnt == WALK_LAST) w_state_nxt = AFTER_WORDS;
`endif
      end
`ifdef CHANY_BIST_PRBS_EN
      ST_PRBS: begin
        w_tx_vld = 1'b1;
        for (int unsigned j = 0; j < CHAN_WIDTH; j++) w_tx[j] = w_lfsr[j % LFSR_W];
        if (r_cnt == PRBS_LAST) w_state_nxt = AFTER_WORDS;
      end
`endif
      ST_DRAIN: if (r_cnt == DRAIN_LAST) w_state_nxt = ST_DONE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge pReset) begin
    if (pReset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state || !busy) r_cnt <= '0;
      else                                 r_cnt <= r_cnt + 1'b1;
    end
  end

  // Stage 0 is the word on the wire; RT_LAT-1 registers align it with chany_rx.
  if (RT_LAT == 1) begin : g_no_dly
    assign w_exp     = w_tx;
    assign w_exp_vld = w_tx_vld;
  end else begin : g_dly
    logic [0:CHAN_WIDTH-1] r_exp_pipe [RT_LAT-1];
    logic [RT_LAT-2:0]     r_vld_pipe;

    always_ff @(posedge clk or posedge pReset) begin
      if (pReset) begin
        r_vld_pipe <= '0;
        for (int unsigned i = 0; i < RT_LAT - 1; i++) r_exp_pipe[i] <= '0;
      end else begin
        r_exp_pipe[0] <= w_tx;
        r_vld_pipe[0] <= w_tx_vld;
        for (int unsigned i = 1; i < RT_LAT - 1; i++) begin
          r_exp_pipe[i] <= r_exp_pipe[i-1];
          r_vld_pipe[i] <= r_vld_pipe[i-1];
        end
      end
    end

    assign w_exp     = r_exp_pipe[RT_LAT-2];
    assign w_exp_vld = r_vld_pipe[RT_LAT-2];
  end

  always_comb begin
    w_diff_scan = '0;
    for (int unsigned j = 0; j < CHAN_WIDTH; j++) w_diff_scan[j] = w_exp[j] ^ chany_rx[j];
  end

  assign w_mismatch = w_exp_vld && (|w_diff_scan);

  always_ff @(posedge clk or posedge pReset) begin
    if (pReset) begin
      r_err_count  <= '0;
      r_fail_track <= '0;
      r_first_seen <= 1'b0;
    end else if (w_accept) begin
      r_err_count  <= '0;
      r_fail_track <= '0;
      r_first_seen <= 1'b0;
    end else if (w_mismatch) begin
      if (r_err_count != '1) r_err_count <= r_err_count + 1'b1;
      if (!r_first_seen) begin
        r_first_seen <= 1'b1;
        r_fail_track <= FT_W'(lowest_set(w_diff_scan));
      end
    end
  end

  assign chany_tx   = w_tx;
  assign fail_track = r_fail_track;
  assign err_count  = r_err_count;

endmodule

// File: tb/tb_chany_track_bist.sv
// Self-checking bench for chany_track_bist: loopback faults, latency, reset and restart.
module tb_chany_track_bist;

  localparam int unsigned CW   = 33;
  localparam int unsigned PLEN = 256;
  localparam logic [30:0] SEED = 31'h1;
`ifdef CHANY_BIST_PRBS_EN
  localparam int unsigned NWORDS = 2 * CW + PLEN;
`else
  localparam int unsigned NWORDS = 2 * CW;
`endif
  localparam int unsigned FT_W = $clog2(CW);
  localparam int unsigned LAT1 = NWORDS + 1;
  localparam int unsigned LAT3 = NWORDS + 3;

  typedef logic [0:CW-1] word_t;

  logic            clk;
  logic            rst;
  logic            start1, start3;
  word_t           tx1, rx1, tx3, rx3;
  logic            busy1, done1, pass1, busy3, done3, pass3;
  logic [FT_W-1:0] ft1, ft3;
  logic [15:0]     err1, err3;

  int    ch_mode, ch_a, ch_b;
  bit    two_flop;
  word_t d1, d2;
  word_t words[$];
  int    n_cmp, n_fail;

  chany_track_bist #(.CHAN_WIDTH(CW), .RT_LAT(1), .PRBS_LEN(PLEN), .PRBS_SEED(SEED)) u_dut1 (
    .clk(clk), .pReset(rst), .start(start1), .chany_tx(tx1), .chany_rx(rx1),
    .busy(busy1), .done(done1), .pass(pass1), .fail_track(ft1), .err_count(err1)
  );

  chany_track_bist #(.CHAN_WIDTH(CW), .RT_LAT(3), .PRBS_LEN(PLEN), .PRBS_SEED(SEED)) u_dut3 (
    .clk(clk), .pReset(rst), .start(start3), .chany_tx(tx3), .chany_rx(rx3),
    .busy(busy3), .done(done3), .pass(pass3), .fail_track(ft3), .err_count(err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic word_t chan(input word_t w, input int mode, input int a, input int b);
    word_t r;
    logic  v;
    r = w;
    case (mode)
      1: r[a] = 1'b0;
      2: r[a] = 1'b1;
      3: begin v = w[a] | w[b]; r[a] = v; r[b] = v; end
      default: ;
    endcase
    return r;
  endfunction

  always_comb rx1 = chan(tx1, ch_mode, ch_a, ch_b);

  always_ff @(posedge clk) begin
    d1 <= tx3;
    d2 <= d1;
  end
  assign rx3 = two_flop ? d2 : d1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build_words();
    word_t       w;
    int unsigned s;
    for (int k = 0; k < int'(CW); k++) begin w = '0; w[k] = 1'b1; words.push_back(w); end
    for (int k = 0; k < int'(CW); k++) begin w = '1; w[k] = 1'b0; words.push_back(w); end
`ifdef CHANY_BIST_PRBS_EN
    s = 32'(SEED);
    for (int n = 0; n < int'(PLEN); n++) begin
      for (int j = 0; j < int'(CW); j++) w[j] = ((s >> (j % 31)) & 1) != 0;
      words.push_back(w);
      s = ((s << 1) | (((s >> 30) ^ (s >> 27)) & 1)) & 32'h7FFF_FFFF;
    end
`else
    s = 0;
`endif
  endtask

  // Expected result: per-word comparison of what the far end returns at compare time.
  task automatic model(input int sel, output int e_err, output int e_ft);
    word_t got, diff;
    bit    seen;
    e_err = 0; e_ft = 0; seen = 0;
    for (int n = 0; n < int'(NWORDS); n++) begin
      if (sel == 0)      got = chan(words[n], ch_mode, ch_a, ch_b);
      else if (two_flop) got = words[n];
      else if (n + 1 < int'(NWORDS)) got = words[n+1];
      else               got = '0;
      diff = got ^ words[n];
      if (diff != '0) begin
        if (e_err < 65535) e_err++;
        if (!seen) begin
          seen = 1;
          for (int i = int'(CW) - 1; i >= 0; i--) if (diff[i]) e_ft = i;
        end
      end
    end
  endtask

  task automatic check_zero(input int sel);
    chk("rst_tx",   sel ? 64'(tx3)   : 64'(tx1),   64'(0));
    chk("rst_busy", sel ? 64'(busy3) : 64'(busy1), 64'(0));
    chk("rst_done", sel ? 64'(done3) : 64'(done1), 64'(0));
    chk("rst_pass", sel ? 64'(pass3) : 64'(pass1), 64'(0));
    chk("rst_ft",   sel ? 64'(ft3)   : 64'(ft1),   64'(0));
    chk("rst_err",  sel ? 64'(err3)  : 64'(err1),  64'(0));
  endtask

  // Entered and left at #1 after a rising edge. Cycle c is the c-th cycle after the accepting edge.
  task automatic run(input int sel, input int unsigned abort_at, input int unsigned pulse_at);
    int          e_err, e_ft;
    int unsigned lat;
    word_t       txs, exp_tx;
    bit          aborted;
    aborted = 0;
    lat = sel ? LAT3 : LAT1;
    model(sel, e_err, e_ft);
    if (sel == 0) start1 = 1'b1; else start3 = 1'b1;
    for (int unsigned c = 1; c <= lat; c++) begin
      @(posedge clk); #1;
      start1 = (sel == 0) && (c == pulse_at);
      start3 = (sel == 1) && (c == pulse_at);
      if (c == abort_at) begin
        rst = 1'b1;
        #1;
        check_zero(sel);
        @(posedge clk); #1;
        rst = 1'b0;
        aborted = 1;
        break;
      end
      txs = sel ? tx3 : tx1;
      exp_tx = '0;
      if (c <= NWORDS) exp_tx = words[c-1];
      chk("tx",   64'(txs), 64'(exp_tx));
      chk("busy", sel ? 64'(busy3) : 64'(busy1), 64'(c < lat));
      chk("done", sel ? 64'(done3) : 64'(done1), 64'(c == lat));
    end
    if (!aborted) begin
      chk("err_count",  sel ? 64'(err3)  : 64'(err1),  64'(e_err));
      chk("fail_track", sel ? 64'(ft3)   : 64'(ft1),   64'(e_ft));
      chk("pass",       sel ? 64'(pass3) : 64'(pass1), 64'(e_err == 0));
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rst = 1'b1; start1 = 1'b0; start3 = 1'b0;
    ch_mode = 0; ch_a = 0; ch_b = 0; two_flop = 1'b1;
    build_words();
    repeat (3) @(posedge clk);
    #1;
    check_zero(0);
    check_zero(1);
    rst = 1'b0;
    @(posedge clk); #1;

    run(0, 0, 0);                                   // clean loopback
    ch_mode = 1; ch_a = 5; run(0, 0, 0);            // stuck-at-0 track 5, restart from DONE
    chk("stuck5_ft", 64'(ft1), 64'(5));
    ch_mode = 3; ch_a = 3; ch_b = 4; run(0, 0, 0);  // wired-OR bridge 3/4
    chk("bridge_ft", 64'(ft1), 64'(4));
    ch_mode = 0; run(0, 0, 50);                     // start while busy is ignored

    for (int t = 0; t < 4; t++) begin
      ch_mode = int'($urandom_range(1, 3));
      ch_a    = int'($urandom_range(0, CW - 1));
      ch_b    = (ch_a + int'($urandom_range(1, CW - 1))) % int'(CW);
      run(0, 0, 0);
    end

    ch_mode = 1; ch_a = 5; run(0, 100, 0);          // reset mid-test
    ch_mode = 0; run(0, 0, 0);

    two_flop = 1'b1; run(1, 0, 0);                  // 2-flop loop matches RT_LAT=3
    two_flop = 1'b0; run(1, 0, 0);                  // misaligned loop must fail
    chk("misalign_pass", 64'(pass3), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
